// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin two-requester controller for one asynchronous
// 6264-class SRAM. Each granted access runs SETUP, STROBE (RD_WAIT/WR_WAIT
// cycles, minimum 1) and RECOVER, then returns a one-cycle ACK, plus RDATA
// for reads. All outputs are registered.
//
// Ports:
//   CLK, nRESET                 clock, asynchronous active-low reset
//   A_REQ/A_WE/A_ADDR/A_WDATA   requester A request (level, held until ACK)
//   A_ACK, A_RDATA              requester A completion pulse and read data
//   B_*                         same set for requester B
//   nCE, nOE, nWE               SRAM strobes (active low)
//   SRAM_A, SRAM_DO, SRAM_DOE   SRAM address, write data, data-bus drive enable
//   SRAM_DI                     data from the SRAM bus
module sram_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int RD_WAIT    = 2,
  parameter int WR_WAIT    = 2
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  input  logic                  A_REQ,
  input  logic                  A_WE,
  input  logic [ADDR_WIDTH-1:0] A_ADDR,
  input  logic [DATA_WIDTH-1:0] A_WDATA,
  output logic                  A_ACK,
  output logic [DATA_WIDTH-1:0] A_RDATA,
  input  logic                  B_REQ,
  input  logic                  B_WE,
  input  logic [ADDR_WIDTH-1:0] B_ADDR,
  input  logic [DATA_WIDTH-1:0] B_WDATA,
  output logic                  B_ACK,
  output logic [DATA_WIDTH-1:0] B_RDATA,
  output logic                  nCE,
  output logic                  nOE,
  output logic                  nWE,
  output logic [ADDR_WIDTH-1:0] SRAM_A,
  output logic [DATA_WIDTH-1:0] SRAM_DO,
  output logic                  SRAM_DOE,
  input  logic [DATA_WIDTH-1:0] SRAM_DI
);

  // Wait states below 1 are clamped so a strobe always lasts at least one cycle.
  localparam int unsigned RD_W  = (RD_WAIT < 1) ? 1 : RD_WAIT;
  localparam int unsigned WR_W  = (WR_WAIT < 1) ? 1 : WR_WAIT;
  localparam int unsigned MAX_W = (RD_W > WR_W) ? RD_W : WR_W;
  localparam int unsigned CNT_W = $clog2(MAX_W + 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;

  state_t           state;
  logic             last_b;   // 1 when B was granted most recently
  logic             cur_b;    // grantee of the access in progress
  logic             cur_we;
  logic [CNT_W-1:0] cnt;

  logic                  grant_a_c;
  logic                  grant_b_c;
  logic                  sel_we_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic [DATA_WIDTH-1:0] sel_wdata_c;

  // Round-robin pick: a lone request wins, otherwise the one not granted last.
  always_comb begin
    grant_a_c   = A_REQ && (!B_REQ || last_b);
    grant_b_c   = B_REQ && (!A_REQ || !last_b);
    sel_we_c    = grant_b_c ? B_WE    : A_WE;
    sel_addr_c  = grant_b_c ? B_ADDR  : A_ADDR;
    sel_wdata_c = grant_b_c ? B_WDATA : A_WDATA;
  end

  // Access sequencer with registered SRAM strobes and requester handshakes.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      cur_b    <= 1'b0;
      cur_we   <= 1'b0;
      cnt      <= '0;
      nCE      <= 1'b1;
      nOE      <= 1'b1;
      nWE      <= 1'b1;
      SRAM_DOE <= 1'b0;
      SRAM_A   <= '0;
      SRAM_DO  <= '0;
      A_ACK    <= 1'b0;
      B_ACK    <= 1'b0;
      A_RDATA  <= '0;
      B_RDATA  <= '0;
    end else begin
      A_ACK <= 1'b0;
      B_ACK <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_a_c || grant_b_c) begin
            cur_b    <= grant_b_c;
            last_b   <= grant_b_c;
            cur_we   <= sel_we_c;
            SRAM_A   <= sel_addr_c;
            SRAM_DO  <= sel_wdata_c;
            nCE      <= 1'b0;
            SRAM_DOE <= sel_we_c;
            state    <= SETUP;
          end
        end
        SETUP: begin
          cnt   <= cur_we ? CNT_W'(WR_W) : CNT_W'(RD_W);
          nOE   <= cur_we;
          nWE   <= !cur_we;
          state <= STROBE;
        end
        STROBE: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            nOE   <= 1'b1;
            nWE   <= 1'b1;
            state <= RECOVER;
            if (cur_b) B_ACK <= 1'b1;
            else       A_ACK <= 1'b1;
            // Read data is taken on the edge that closes the last strobe cycle.
            if (!cur_we) begin
              if (cur_b) B_RDATA <= SRAM_DI;
              else       A_RDATA <= SRAM_DI;
            end
          end
        end
        RECOVER: begin
          // Data and address were held through this cycle; release the bus now.
          nCE      <= 1'b1;
          SRAM_DOE <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and randomized checks of sram_arbiter against a
// timeline model of each access (offsets from the grant edge).
module tb_sram_arbiter;
  localparam int AW     = 13;
  localparam int DW     = 8;
  localparam int RD_P   = 0;
  localparam int WR_P   = 3;
  localparam int RD_EFF = (RD_P < 1) ? 1 : RD_P;
  localparam int WR_EFF = (WR_P < 1) ? 1 : WR_P;

  logic clk = 1'b0;
  logic n_reset;
  logic a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr, sram_a;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, sram_do, sram_di;
  logic a_ack, b_ack, n_ce, n_oe, n_we, sram_doe;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 0;
  int noe_lo, nwe_lo, doe_hi;
  int ack_id[$];
  int ack_cy[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_WAIT(RD_P), .WR_WAIT(WR_P)) dut (
    .CLK(clk), .nRESET(n_reset),
    .A_REQ(a_req), .A_WE(a_we), .A_ADDR(a_addr), .A_WDATA(a_wdata), .A_ACK(a_ack), .A_RDATA(a_rdata),
    .B_REQ(b_req), .B_WE(b_we), .B_ADDR(b_addr), .B_WDATA(b_wdata), .B_ACK(b_ack), .B_RDATA(b_rdata),
    .nCE(n_ce), .nOE(n_oe), .nWE(n_we), .SRAM_A(sram_a), .SRAM_DO(sram_do),
    .SRAM_DOE(sram_doe), .SRAM_DI(sram_di));

  // SRAM device: drives real data only while selected with nOE low.
  logic [DW-1:0] dev_mem [1<<AW];
  logic [DW-1:0] ref_mem [1<<AW];
  assign sram_di = (!n_ce && !n_oe) ? dev_mem[sram_a] : ~dev_mem[sram_a];
  always @(posedge n_we) if (n_reset && !n_ce) dev_mem[sram_a] = sram_do;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one access timeline at a time, offset m_k counted from the grant edge.
  bit          m_busy, m_g, m_last, m_we;
  int          m_k, m_w;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_do;
  logic [DW-1:0] m_rdata [2];

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_busy = 0; m_k = 0; m_last = 1; m_g = 0; m_we = 0; m_w = 1;
      m_a = '0; m_do = '0; m_rdata[0] = '0; m_rdata[1] = '0;
    end else begin
      if (m_busy) begin
        m_k++;
        if (m_k == m_w + 1) begin
          if (m_we) ref_mem[m_a] = m_do;
          else      m_rdata[m_g] = ref_mem[m_a];
        end
        if (m_k == m_w + 3) m_busy = 0;
      end
      if (!m_busy && (a_req || b_req)) begin
        m_g    = (a_req && b_req) ? !m_last : b_req;
        m_last = m_g;
        m_we   = m_g ? b_we : a_we;
        m_a    = m_g ? b_addr : a_addr;
        m_do   = m_g ? b_wdata : a_wdata;
        m_w    = m_we ? WR_EFF : RD_EFF;
        m_busy = 1;
        m_k    = 0;
      end
    end
  end

  // Per-cycle compare against the model, plus activity counters and ACK log.
  always @(negedge clk) begin
    logic act_win, strobe;
    act_win = m_busy && (m_k <= m_w + 1);
    strobe  = m_busy && (m_k >= 1) && (m_k <= m_w);
    if (mon_en) begin
      check("nce", n_ce, !act_win);
      check("noe", n_oe, !(strobe && !m_we));
      check("nwe", n_we, !(strobe && m_we));
      check("doe", sram_doe, act_win && m_we);
      check("a_ack", a_ack, m_busy && m_k == m_w + 1 && !m_g);
      check("b_ack", b_ack, m_busy && m_k == m_w + 1 && m_g);
      check("sram_a", sram_a, m_a);
      check("sram_do", sram_do, m_do);
      check("a_rdata", a_rdata, m_rdata[0]);
      check("b_rdata", b_rdata, m_rdata[1]);
    end
    if (!n_oe) noe_lo++;
    if (!n_we) nwe_lo++;
    if (sram_doe) doe_hi++;
    if (a_ack) begin ack_id.push_back(0); ack_cy.push_back(cyc); end
    if (b_ack) begin ack_id.push_back(1); ack_cy.push_back(cyc); end
  end

  task automatic set_req(input int id, input logic r, input logic we,
                         input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    if (id == 0) begin a_req = r; a_we = we; a_addr = ad; a_wdata = wd; end
    else         begin b_req = r; b_we = we; b_addr = ad; b_wdata = wd; end
  endtask

  task automatic do_access(input int id, input logic we, input logic [AW-1:0] ad,
                           input logic [DW-1:0] wd, output int t_req, output int t_ack);
    int n = 0;
    logic got;
    @(posedge clk); #1;
    set_req(id, 1'b1, we, ad, wd);
    t_req = cyc;
    do begin
      @(negedge clk); n++;
      got = (id == 0) ? a_ack : b_ack;
    end while (!got && n < 200);
    t_ack = cyc;
    check("ack_wait", got, 1'b1);
    @(posedge clk); #1;
    set_req(id, 1'b0, 1'($urandom), AW'($urandom), DW'($urandom));
  endtask

  task automatic rand_requester(input int id, input int n);
    int tr, ta;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_access(id, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom), tr, ta);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int tr, ta, base;
    for (int i = 0; i < (1 << AW); i++) begin
      dev_mem[i] = DW'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    dev_mem[13'h0123] = 8'h5A; ref_mem[13'h0123] = 8'h5A;
    n_reset = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    check("rst_nce", n_ce, 1'b1);
    check("rst_noe", n_oe, 1'b1);
    check("rst_nwe", n_we, 1'b1);
    check("rst_doe", sram_doe, 1'b0);
    check("rst_rdata", {a_rdata, b_rdata}, 16'h0000);
    n_reset = 1'b1;
    mon_en  = 1;
    repeat (20) @(posedge clk);
    check("idle_no_ack", ack_id.size(), 0);

    // Single A read, clamped read wait of one cycle.
    noe_lo = 0;
    do_access(0, 1'b0, 13'h0123, 8'h00, tr, ta);
    check("rd_data", a_rdata, 8'h5A);
    check("rd_b_hold", b_rdata, 8'h00);
    check("rd_noe_cycles", noe_lo, 1);
    check("rd_latency", ta - tr, 3);

    // B write with three wait states, then readback.
    nwe_lo = 0; doe_hi = 0;
    do_access(1, 1'b1, 13'h1FFF, 8'hC3, tr, ta);
    check("wr_nwe_cycles", nwe_lo, 3);
    check("wr_doe_cycles", doe_hi, 5);
    check("wr_latency", ta - tr, 5);
    do_access(1, 1'b0, 13'h1FFF, 8'h00, tr, ta);
    check("wr_readback", b_rdata, 8'hC3);

    // Continuous contention: strict alternation starting with A.
    base = ack_id.size();
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 13'h0123, 8'h00);
    set_req(1, 1'b1, 1'b0, 13'h1FFF, 8'h00);
    for (int n = 0; n < 100 && ack_id.size() < base + 4; n++) @(negedge clk);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    check("cont_acks", ack_id.size() - base >= 4, 1'b1);
    if (ack_id.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) check("cont_order", ack_id[base + i], i % 2);
      for (int i = 1; i < 4; i++) check("cont_gap", ack_cy[base + i] - ack_cy[base + i - 1], 4);
    end
    repeat (4) @(posedge clk);

    // Reset during a write strobe: abandoned, outputs released at once.
    base = ack_id.size();
    @(posedge clk); #1;
    set_req(1, 1'b1, 1'b1, 13'h0040, 8'h77);
    for (int n = 0; n < 50 && n_we; n++) @(negedge clk);
    check("abort_strobe_seen", n_we, 1'b0);
    #2 n_reset = 1'b0;
    #1;
    check("abort_nwe", n_we, 1'b1);
    check("abort_nce", n_ce, 1'b1);
    check("abort_doe", sram_doe, 1'b0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk); n_reset = 1'b1;
    check("abort_no_ack", ack_id.size() - base, 0);
    fork
      do_access(0, 1'b0, 13'h0005, 8'h00, tr, ta);
      begin int t1, t2; do_access(1, 1'b0, 13'h0006, 8'h00, t1, t2); end
    join
    check("post_reset_first", ack_id.size() > base && ack_id[base] == 0, 1'b1);

    // Randomized traffic from both requesters.
    fork
      rand_requester(0, 150);
      rand_requester(1, 150);
    join
    repeat (10) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
